adder_share_arbiter: RTL and testbench

Two-requester controller sharing a single external 3-bit ripple adder (`threebit` instance: 3-bit x/y in, 3-bit Sum plus Cout out). It arbitrates round-robin between two valid/ready request channels and drives the granted operands into the adder. It captures the adder's Sum/Cout into a registered result and returns it on the matching response channel. The block sits between the operand sources and the adder, and is the only driver of the adder's inputs.

---
 rtl/adder_share_arbiter_if.sv | 38 +++
 rtl/adder_share_arbiter.sv | 155 +++++++++++++++
 tb/tb_adder_share_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arbiter_if.sv
// Request/response channel bundle between two operand sources and the
// shared-adder arbiter. The master side is the requester/consumer; the
// slave side is the arbiter.
interface adder_share_arbiter_if #(
   parameter int W = 3
);
   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_x;
   logic [W-1:0] req0_y;
   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_x;
   logic [W-1:0] req1_y;

   logic         rsp0_valid;
   logic         rsp0_ready;
   logic [W-1:0] rsp0_sum;
   logic         rsp0_cout;
   logic         rsp1_valid;
   logic         rsp1_ready;
   logic [W-1:0] rsp1_sum;
   logic         rsp1_cout;

   modport master (
      output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_sum, rsp0_cout, rsp1_valid, rsp1_sum, rsp1_cout,
      output rsp0_ready, rsp1_ready
   );

   modport slave (
      input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_sum, rsp0_cout, rsp1_valid, rsp1_sum, rsp1_cout,
      input  rsp0_ready, rsp1_ready
   );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external 3-bit adder between two
// requesters. One operation walks IDLE -> EXEC -> RESP; the adder sees the
// granted operands only during EXEC and its result is held in RESP until
// the owning consumer takes it.
module adder_share_arbiter #(
   parameter int W = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   adder_share_arbiter_if.slave bus,
   output logic [W-1:0]         add_x,
   output logic [W-1:0]         add_y,
   input  logic [W-1:0]         add_sum,
   input  logic                 add_cout,
   output logic                 busy,
   output logic                 grant,
   output logic [7:0]           ops_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic         last_grant_q, last_grant_d;
   logic         grant_q, grant_d;
   logic [W-1:0] op_x_q, op_x_d;
   logic [W-1:0] op_y_q, op_y_d;
   logic [W-1:0] res_sum_q, res_sum_d;
   logic         res_cout_q, res_cout_d;
   logic [7:0]   ops_done_q, ops_done_d;

   logic sel_s;
   logic idle_s;
   logic resp_s;
   logic hs_s;
   logic rsp_hs_s;
   logic rsp0_valid_s;
   logic rsp1_valid_s;

   // Pick the candidate channel: a lone requester wins, a tie goes to the
   // channel that did not own the adder last.
   always_comb begin
      sel_s = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         sel_s = ~last_grant_q;
      end else if (bus.req1_valid) begin
         sel_s = 1'b1;
      end else begin
         sel_s = 1'b0;
      end
   end

   assign idle_s         = (state_q == IDLE);
   assign resp_s         = (state_q == RESP);
   assign bus.req0_ready = idle_s & ~sel_s & bus.req0_valid;
   assign bus.req1_ready = idle_s &  sel_s & bus.req1_valid;
   assign hs_s           = bus.req0_ready | bus.req1_ready;

   assign rsp0_valid_s   = resp_s & ~grant_q;
   assign rsp1_valid_s   = resp_s &  grant_q;
   assign rsp_hs_s       = grant_q ? (rsp1_valid_s & bus.rsp1_ready)
                                   : (rsp0_valid_s & bus.rsp0_ready);

   assign bus.rsp0_valid = rsp0_valid_s;
   assign bus.rsp1_valid = rsp1_valid_s;
   assign bus.rsp0_sum   = rsp0_valid_s ? res_sum_q  : {W{1'b0}};
   assign bus.rsp0_cout  = rsp0_valid_s ? res_cout_q : 1'b0;
   assign bus.rsp1_sum   = rsp1_valid_s ? res_sum_q  : {W{1'b0}};
   assign bus.rsp1_cout  = rsp1_valid_s ? res_cout_q : 1'b0;

   // Operand registers are non-zero only during EXEC, so the adder inputs
   // come straight from flops and read 0 in every other state.
   assign add_x    = op_x_q;
   assign add_y    = op_y_q;
   assign busy     = ~idle_s;
   assign grant    = grant_q;
   assign ops_done = ops_done_q;

   // Next-state and datapath updates for the three-phase operation.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      op_x_d       = op_x_q;
      op_y_d       = op_y_q;
      res_sum_d    = res_sum_q;
      res_cout_d   = res_cout_q;
      ops_done_d   = ops_done_q;
      case (state_q)
         IDLE: begin
            if (hs_s) begin
               state_d = EXEC;
               grant_d = sel_s;
               if (sel_s) begin
                  op_x_d = bus.req1_x;
                  op_y_d = bus.req1_y;
               end else begin
                  op_x_d = bus.req0_x;
                  op_y_d = bus.req0_y;
               end
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            res_sum_d  = add_sum;
            res_cout_d = add_cout;
            op_x_d     = {W{1'b0}};
            op_y_d     = {W{1'b0}};
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_hs_s) begin
               ops_done_d   = ops_done_q + 8'd1;
               last_grant_d = grant_q;
               state_d      = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
            op_x_d  = {W{1'b0}};
            op_y_d  = {W{1'b0}};
         end
      endcase
   end

   // State and datapath registers; reset abandons any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         op_x_q       <= {W{1'b0}};
         op_y_q       <= {W{1'b0}};
         res_sum_q    <= {W{1'b0}};
         res_cout_q   <= 1'b0;
         ops_done_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         op_x_q       <= op_x_d;
         op_y_q       <= op_y_d;
         res_sum_q    <= res_sum_d;
         res_cout_q   <= res_cout_d;
         ops_done_q   <= ops_done_d;
      end
   end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter. A behavioural 3-bit adder
// sits on the add_* port; expected results, grant order and latencies come
// from plain arithmetic and a small model of who won last.
module tb_adder_share_arbiter;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] add_x, add_y, add_sum;
   logic         add_cout, busy, grant;
   logic [7:0]   ops_done;

   int         checks = 0;
   int         errors = 0;
   logic       exp_last;
   logic [7:0] exp_ops;

   adder_share_arbiter_if #(.W(W)) bus ();

   adder_share_arbiter #(.W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .add_x    (add_x),
      .add_y    (add_y),
      .add_sum  (add_sum),
      .add_cout (add_cout),
      .busy     (busy),
      .grant    (grant),
      .ops_done (ops_done)
   );

   always #5 clk = ~clk;

   // external ripple adder
   assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      bus.req0_valid = 1'b0; bus.req0_x = 3'd0; bus.req0_y = 3'd0;
      bus.req1_valid = 1'b0; bus.req1_x = 3'd0; bus.req1_y = 3'd0;
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      exp_last = 1'b1;
      exp_ops  = 8'd0;
   endtask

   task automatic test_reset();
      logic [15:0] got;
      do_reset();
      #1;
      got = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, busy, grant, add_x, add_y, ops_done[3:0]};
      checks++;
      if (got !== 16'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", got); end
      got = {2'b00, bus.rsp0_sum, bus.rsp0_cout, bus.rsp1_sum, bus.rsp1_cout, ops_done};
      checks++;
      if (got !== 16'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", got); end
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [7:0] got;
      bus.req0_valid = 1'b1; bus.req0_x = 3'd6; bus.req0_y = 3'd1; bus.rsp0_ready = 1'b1;
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL single_accept: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
      @(negedge clk);
      bus.req0_valid = 1'b0;
      #1;
      got = {busy, grant, add_x, add_y};
      checks++;
      if (got !== {1'b1, 1'b0, 3'd6, 3'd1}) begin errors++; $display("FAIL single_exec: got %h expected %h", got, {1'b1, 1'b0, 3'd6, 3'd1}); end
      checks++;
      if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %b expected 0", bus.rsp0_valid); end
      @(negedge clk);
      got = {bus.rsp0_valid, bus.rsp0_sum, bus.rsp0_cout, add_x[0], add_y[0], 1'b0};
      checks++;
      if ({bus.rsp0_valid, bus.rsp0_sum, bus.rsp0_cout, add_x, add_y} !== {1'b1, 3'd7, 1'b0, 6'd0}) begin
         errors++; $display("FAIL single_rsp: got %h expected %h", {bus.rsp0_valid, bus.rsp0_sum, bus.rsp0_cout, add_x, add_y}, {1'b1, 3'd7, 1'b0, 6'd0});
      end
      @(negedge clk);
      bus.rsp0_ready = 1'b0;
      exp_ops++; exp_last = 1'b0;
      checks++;
      if ({ops_done, busy} !== {exp_ops, 1'b0}) begin errors++; $display("FAIL single_done: got ops %0d busy %b expected ops %0d busy 0", ops_done, busy, exp_ops); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] xs [2];
      logic [2:0] ys [2];
      int         acc_cyc [2];
      int         n_acc = 0, n_rsp = 0;
      logic [3:0] s;
      xs[0] = 3'd2; ys[0] = 3'd3; xs[1] = 3'd5; ys[1] = 3'd4;
      bus.rsp1_ready = 1'b1;
      for (int c = 0; c < 40 && n_rsp < 2; c++) begin
         if (n_acc < 2) begin
            bus.req1_valid = 1'b1; bus.req1_x = xs[n_acc]; bus.req1_y = ys[n_acc];
         end else begin
            bus.req1_valid = 1'b0;
         end
         #1;
         checks++;
         if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL b2b_rsp0_quiet: got %b expected 0 at cycle %0d", bus.rsp0_valid, c); end
         if (bus.req1_ready === 1'b1 && n_acc < 2) begin acc_cyc[n_acc] = c; n_acc++; end
         if (bus.rsp1_valid === 1'b1) begin
            s = {1'b0, xs[n_rsp]} + {1'b0, ys[n_rsp]};
            checks++;
            if ({bus.rsp1_sum, bus.rsp1_cout} !== {s[2:0], s[3]}) begin
               errors++; $display("FAIL b2b_result%0d: got sum %0d cout %b expected sum %0d cout %b", n_rsp, bus.rsp1_sum, bus.rsp1_cout, s[2:0], s[3]);
            end
            n_rsp++; exp_ops++; exp_last = 1'b1;
         end
         @(negedge clk);
      end
      bus.req1_valid = 1'b0; bus.rsp1_ready = 1'b0;
      checks++;
      if (n_rsp != 2 || n_acc != 2) begin errors++; $display("FAIL b2b_count: got %0d accepts %0d responses expected 2 and 2", n_acc, n_rsp); end
      else begin
         checks++;
         if (acc_cyc[1] - acc_cyc[0] != 3) begin errors++; $display("FAIL b2b_spacing: got %0d cycles expected 3", acc_cyc[1] - acc_cyc[0]); end
      end
      checks++;
      if (ops_done !== exp_ops) begin errors++; $display("FAIL b2b_ops_done: got %0d expected %0d", ops_done, exp_ops); end
   endtask

   task automatic test_alternate();
      int   cnt [2];
      int   q [$];
      int   n_acc = 0, n_rsp = 0, last_acc = -1;
      logic ch;
      do_reset();
      cnt[0] = 0; cnt[1] = 0;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      bus.req0_x = 3'd7; bus.req0_y = 3'd7; bus.req1_x = 3'd7; bus.req1_y = 3'd7;
      for (int c = 0; c < 100 && n_rsp < 6; c++) begin
         bus.req0_valid = (cnt[0] < 3);
         bus.req1_valid = (cnt[1] < 3);
         #1;
         checks++;
         if ((bus.req0_ready & bus.req1_ready) !== 1'b0) begin errors++; $display("FAIL alt_one_ready: got both ready at cycle %0d expected one", c); end
         if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
            ch = bus.req1_ready;
            checks++;
            if (ch !== 1'(n_acc % 2)) begin errors++; $display("FAIL alt_grant%0d: got ch %0d expected ch %0d", n_acc, ch, n_acc % 2); end
            if (last_acc >= 0) begin
               checks++;
               if (c - last_acc != 3) begin errors++; $display("FAIL alt_spacing: got %0d cycles expected 3", c - last_acc); end
            end
            last_acc = c; cnt[ch]++; n_acc++; q.push_back(int'(ch));
         end
         if (bus.rsp0_valid === 1'b1 || bus.rsp1_valid === 1'b1) begin
            ch = bus.rsp1_valid;
            checks++;
            if (q.size() == 0 || int'(ch) != q[0] || bus.rsp0_valid === bus.rsp1_valid) begin
               errors++; $display("FAIL alt_rsp_chan: got rsp0 %b rsp1 %b expected single channel from queue", bus.rsp0_valid, bus.rsp1_valid);
            end
            checks++;
            if ((ch ? {bus.rsp1_sum, bus.rsp1_cout} : {bus.rsp0_sum, bus.rsp0_cout}) !== {3'd6, 1'b1}) begin
               errors++; $display("FAIL alt_result: got %h expected sum 6 cout 1", ch ? {bus.rsp1_sum, bus.rsp1_cout} : {bus.rsp0_sum, bus.rsp0_cout});
            end
            if (q.size() > 0) void'(q.pop_front());
            n_rsp++; exp_ops++; exp_last = ch;
         end
         @(negedge clk);
      end
      clear_inputs();
      checks++;
      if (n_rsp != 6) begin errors++; $display("FAIL alt_count: got %0d responses expected 6", n_rsp); end
      checks++;
      if (ops_done !== 8'd6) begin errors++; $display("FAIL alt_ops_done: got %0d expected 6", ops_done); end
   endtask

   task automatic test_backpressure();
      logic [7:0] got;
      bus.req0_valid = 1'b1; bus.req0_x = 3'd5; bus.req0_y = 3'd6;
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b expected 1", bus.req0_ready); end
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_x = 3'd3; bus.req1_y = 3'd3;
      @(negedge clk);
      for (int h = 0; h < 6; h++) begin
         bus.rsp0_ready = (h == 5);
         #1;
         got = {busy, bus.rsp0_valid, bus.rsp0_sum, bus.rsp0_cout, bus.req1_ready, bus.rsp1_valid};
         checks++;
         if (got !== {1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL bp_hold%0d: got %h expected %h", h, got, {1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0});
         end
         @(negedge clk);
      end
      bus.rsp0_ready = 1'b0;
      exp_ops++; exp_last = 1'b0;
      #1;
      checks++;
      if ({bus.req1_ready, ops_done} !== {1'b1, exp_ops}) begin errors++; $display("FAIL bp_next_grant: got ready %b ops %0d expected ready 1 ops %0d", bus.req1_ready, ops_done, exp_ops); end
      @(negedge clk);
      bus.req1_valid = 1'b0; bus.rsp1_ready = 1'b1;
      checks++;
      if ({grant, add_x, add_y} !== {1'b1, 3'd3, 3'd3}) begin errors++; $display("FAIL bp_exec1: got %h expected %h", {grant, add_x, add_y}, {1'b1, 3'd3, 3'd3}); end
      @(negedge clk);
      checks++;
      if ({bus.rsp1_valid, bus.rsp1_sum, bus.rsp1_cout} !== {1'b1, 3'd6, 1'b0}) begin errors++; $display("FAIL bp_rsp1: got %h expected %h", {bus.rsp1_valid, bus.rsp1_sum, bus.rsp1_cout}, {1'b1, 3'd6, 1'b0}); end
      @(negedge clk);
      bus.rsp1_ready = 1'b0;
      exp_ops++; exp_last = 1'b1;
      checks++;
      if (ops_done !== exp_ops) begin errors++; $display("FAIL bp_ops_done: got %0d expected %0d", ops_done, exp_ops); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] got;
      bus.req1_valid = 1'b1; bus.req1_x = 3'd4; bus.req1_y = 3'd4; bus.rsp1_ready = 1'b1;
      @(negedge clk);
      bus.req1_valid = 1'b0;
      checks++;
      if ({busy, grant, add_x} !== {1'b1, 1'b1, 3'd4}) begin errors++; $display("FAIL rstmid_exec: got %h expected %h", {busy, grant, add_x}, {1'b1, 1'b1, 3'd4}); end
      rst = 1'b1;
      #1;
      got = {busy, grant, add_x, add_y, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready, 2'b00};
      checks++;
      if (got !== 16'd0 || ops_done !== 8'd0) begin errors++; $display("FAIL rstmid_async: got %h ops %0d expected 0", got, ops_done); end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({bus.rsp0_valid, bus.rsp1_valid, busy} !== 3'b000) begin errors++; $display("FAIL rstmid_no_rsp: got %b expected 000", {bus.rsp0_valid, bus.rsp1_valid, busy}); end
      end
      rst = 1'b0; exp_last = 1'b1; exp_ops = 8'd0;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      #1;
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL rstmid_prio: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
      clear_inputs();
      @(negedge clk);
      checks++;
      if ({busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin errors++; $display("FAIL rstmid_idle: got %b expected 000", {busy, bus.rsp0_valid, bus.rsp1_valid}); end
   endtask

   task automatic test_random(input int n, input bit single);
      logic [2:0] x0, y0, x1, y1, ex, ey;
      logic [3:0] s;
      logic [1:0] vv;
      logic       ch;
      int         hold;
      for (int k = 0; k < n; k++) begin
         vv = single ? 2'b01 : 2'($urandom_range(1, 3));
         x0 = 3'($urandom); y0 = 3'($urandom); x1 = 3'($urandom); y1 = 3'($urandom);
         bus.req0_valid = vv[0]; bus.req0_x = x0; bus.req0_y = y0;
         bus.req1_valid = vv[1]; bus.req1_x = x1; bus.req1_y = y1;
         bus.rsp0_ready = 1'($urandom); bus.rsp1_ready = 1'($urandom);
         ch = (vv == 2'b11) ? ~exp_last : vv[1];
         ex = ch ? x1 : x0; ey = ch ? y1 : y0;
         s  = {1'b0, ex} + {1'b0, ey};
         #1;
         checks++;
         if ({bus.req1_ready, bus.req0_ready} !== (ch ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_ready%0d: got %b expected ch %0d", k, {bus.req1_ready, bus.req0_ready}, ch); end
         checks++;
         if ({busy, bus.rsp0_valid, bus.rsp1_valid, add_x, add_y} !== 9'd0) begin errors++; $display("FAIL rnd_idle%0d: got %h expected 0", k, {busy, bus.rsp0_valid, bus.rsp1_valid, add_x, add_y}); end
         @(negedge clk);
         if (ch) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
         #1;
         checks++;
         if ({busy, grant, add_x, add_y, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== {1'b1, ch, ex, ey, 4'b0000}) begin
            errors++; $display("FAIL rnd_exec%0d: got %h expected %h", k, {busy, grant, add_x, add_y, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}, {1'b1, ch, ex, ey, 4'b0000});
         end
         @(negedge clk);
         hold = $urandom_range(0, 3);
         for (int h = 0; h <= hold; h++) begin
            if (ch) begin bus.rsp1_ready = (h == hold); bus.rsp0_ready = 1'($urandom); end
            else    begin bus.rsp0_ready = (h == hold); bus.rsp1_ready = 1'($urandom); end
            #1;
            checks++;
            if ({bus.rsp1_valid, bus.rsp1_sum, bus.rsp1_cout, bus.rsp0_valid, bus.rsp0_sum, bus.rsp0_cout} !==
                (ch ? {1'b1, s[2:0], s[3], 5'd0} : {5'd0, 1'b1, s[2:0], s[3]})) begin
               errors++; $display("FAIL rnd_rsp%0d: got %h for ch %0d sum %0d cout %b", k, {bus.rsp1_valid, bus.rsp1_sum, bus.rsp1_cout, bus.rsp0_valid, bus.rsp0_sum, bus.rsp0_cout}, ch, s[2:0], s[3]);
            end
            checks++;
            if ({add_x, add_y, bus.req0_ready, bus.req1_ready, busy} !== {6'd0, 2'b00, 1'b1}) begin
               errors++; $display("FAIL rnd_resp_quiet%0d: got %h expected %h", k, {add_x, add_y, bus.req0_ready, bus.req1_ready, busy}, {6'd0, 2'b00, 1'b1});
            end
            @(negedge clk);
         end
         exp_ops++; exp_last = ch;
         checks++;
         if ({ops_done, busy, bus.rsp0_valid, bus.rsp1_valid} !== {exp_ops, 3'b000}) begin
            errors++; $display("FAIL rnd_done%0d: got ops %0d flags %b expected ops %0d flags 000", k, ops_done, {busy, bus.rsp0_valid, bus.rsp1_valid}, exp_ops);
         end
         bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
      end
      clear_inputs();
   endtask

   task automatic test_wrap();
      do_reset();
      test_random(256, 1'b1);
      checks++;
      if (ops_done !== 8'd0) begin errors++; $display("FAIL wrap_ops_done: got %0d expected 0", ops_done); end
   endtask

   initial begin
      rst = 1'b1;
      exp_last = 1'b1;
      exp_ops  = 8'd0;
      clear_inputs();
      test_reset();
      test_single();
      test_back_to_back();
      test_alternate();
      test_backpressure();
      test_reset_mid();
      test_random(40, 1'b0);
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
